// File: rtl/fb_pkg.sv
// Shared types and geometry for the framebuffer rectangle fill engine.
package fb_pkg;

  localparam int RES_X      = 320;
  localparam int RES_Y      = 240;
  localparam int MEM_WIDTH  = 8;
  localparam int ADDR_WIDTH = $clog2(RES_X * RES_Y);
  localparam int X_W        = $clog2(RES_X + 1);
  localparam int Y_W        = $clog2(RES_Y + 1);

  // One 0b00RRGGBB pixel.
  typedef logic [MEM_WIDTH-1:0] pixel_t;

  typedef struct packed {
    logic [X_W-1:0] x0;
    logic [Y_W-1:0] y0;
    logic [X_W-1:0] w;
    logic [Y_W-1:0] h;
    pixel_t         color;
  } fill_cmd_t;

  typedef enum logic [2:0] {IDLE, SETUP, WAIT_FRAME, FILL, DONE} fill_state_t;

  // Exclusive right edge, clipped to the screen; the sum carries one extra bit
  // so x0+w can never wrap before the comparison.
  function automatic logic [X_W-1:0] clip_x(input logic [X_W-1:0] x0,
                                            input logic [X_W-1:0] w);
    logic [X_W:0] sum;
    sum = {1'b0, x0} + {1'b0, w};
    return (sum > (X_W+1)'(RES_X)) ? X_W'(RES_X) : sum[X_W-1:0];
  endfunction

  // Exclusive bottom edge, clipped to the screen.
  function automatic logic [Y_W-1:0] clip_y(input logic [Y_W-1:0] y0,
                                            input logic [Y_W-1:0] h);
    logic [Y_W:0] sum;
    sum = {1'b0, y0} + {1'b0, h};
    return (sum > (Y_W+1)'(RES_Y)) ? Y_W'(RES_Y) : sum[Y_W-1:0];
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Raster address generator: tracks the pixel currently on the write port and
// offers the address of the next one. row_base is kept incrementally so the
// only multiply is y0*RES_X at load time.
module fb_addr_gen
  import fb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [X_W-1:0]        x0,
  input  logic [Y_W-1:0]        y0,
  input  logic [X_W-1:0]        xe,
  input  logic [Y_W-1:0]        ye,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  last
);

  logic [X_W-1:0]        col;
  logic [Y_W-1:0]        row;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] base_y0;
  logic                  row_end;

  assign base_y0 = ADDR_WIDTH'(y0) * ADDR_WIDTH'(RES_X);
  assign row_end = ({1'b0, col} + (X_W+1)'(1)) == {1'b0, xe};
  assign last    = row_end && (({1'b0, row} + (Y_W+1)'(1)) == {1'b0, ye});

  // Address of the pixel that follows the one currently being written.
  always_comb begin
    // NOTE: next_addr gets a value before any branch, so no path leaves it unassigned and no latch is inferred.
    next_addr = row_base + ADDR_WIDTH'(col) + ADDR_WIDTH'(1);
    if (load)
      next_addr = base_y0 + ADDR_WIDTH'(x0);
    else if (row_end)
      next_addr = row_base + ADDR_WIDTH'(RES_X) + ADDR_WIDTH'(x0);
  end

  // Position counters: load points at the first pixel, step walks raster order.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
    if (rst) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (load) begin
      col      <= x0;
      row      <= y0;
      row_base <= base_y0;
    end else if (step) begin
      if (row_end) begin
        col      <= x0;
        row      <= row + Y_W'(1);
        row_base <= row_base + ADDR_WIDTH'(RES_X);
      end else begin
        col <= col + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: accepts one clipped rectangle per valid/ready
// handshake and writes it into the framebuffer one pixel per clock.
// Optional FB_FILL_VSYNC_GATE_EN adds frame_start and holds each fill in
// WAIT_FRAME until the next frame boundary.
module fb_rect_fill
  import fb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [X_W-1:0]        cmd_x0,
  input  logic [Y_W-1:0]        cmd_y0,
  input  logic [X_W-1:0]        cmd_w,
  input  logic [Y_W-1:0]        cmd_h,
  input  logic [MEM_WIDTH-1:0]  cmd_color,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_WIDTH-1:0]  din,
  output logic                  wen,
  output logic                  busy,
  output logic                  done
`ifdef FB_FILL_VSYNC_GATE_EN
  ,
  input  logic                  frame_start
`endif
);

  fill_state_t           state;
  fill_cmd_t             cmd;
  logic [X_W-1:0]        xe;
  logic [Y_W-1:0]        ye;
  logic                  empty;
  logic                  accept;
  logic                  load;
  logic                  step;
  logic                  last;
  logic [ADDR_WIDTH-1:0] next_addr;

  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  // Clip window derived from the captured command; stable for the whole fill.
  assign xe    = clip_x(cmd.x0, cmd.w);
  assign ye    = clip_y(cmd.y0, cmd.h);
  assign empty = (cmd.w == '0) || (cmd.h == '0) ||
                 (cmd.x0 >= X_W'(RES_X)) || (cmd.y0 >= Y_W'(RES_Y));

`ifdef FB_FILL_VSYNC_GATE_EN
  assign load = (state == WAIT_FRAME) && frame_start;
`else
  assign load = (state == SETUP) && !empty;
`endif
  assign step = (state == FILL) && !last;

  fb_addr_gen u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .x0        (cmd.x0),
    .y0        (cmd.y0),
    .xe        (xe),
    .ye        (ye),
    .next_addr (next_addr),
    .last      (last)
  );

  // Command FSM with registered write port, busy and done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cmd      <= '0;
      mem_addr <= '0;
      din      <= '0;
      wen      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cmd   <= '{x0: cmd_x0, y0: cmd_y0, w: cmd_w, h: cmd_h, color: cmd_color};
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (empty) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
`ifdef FB_FILL_VSYNC_GATE_EN
            state <= WAIT_FRAME;
`else
            mem_addr <= next_addr;
            din      <= cmd.color;
            wen      <= 1'b1;
            state    <= FILL;
`endif
          end
        end
`ifdef FB_FILL_VSYNC_GATE_EN
        WAIT_FRAME: begin
          if (frame_start) begin
            mem_addr <= next_addr;
            din      <= cmd.color;
            wen      <= 1'b1;
            state    <= FILL;
          end
        end
`endif
        FILL: begin
          if (last) begin
            wen   <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            mem_addr <= next_addr;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          wen   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
